// File: rtl/serial_adder.sv
// -----------------------------------------------------------------------------
// serial_adder
//
// Bit-serial WIDTH-bit unsigned adder. A single full-adder cell and a carry
// flip-flop process the captured operands LSB-first, one bit per clock. The
// parallel result is reassembled in a shift register and published on SUM and
// Cout when the last bit has been processed.
//
// Parameters:
//   WIDTH  - operand/result width in bits (>= 2), default 8
//
// Ports:
//   CLK    in   1      system clock, rising edge
//   RST_N  in   1      asynchronous active-low reset
//   START  in   1      load request, sampled only while BUSY = 0
//   A      in   WIDTH  operand A, captured on the accepted START edge
//   B      in   WIDTH  operand B, captured on the accepted START edge
//   Cin    in   1      carry-in, captured on the accepted START edge
//   BUSY   out  1      high while an addition is in progress
//   DONE   out  1      one-cycle pulse: SUM/Cout have just been updated
//   SUM    out  WIDTH  registered result, held until the next completion
//   Cout   out  1      registered carry-out of bit WIDTH-1
//   OVF    out  1      (only with SERIAL_ADDER_OVF_EN) signed overflow flag
//
// Build option:
//   SERIAL_ADDER_OVF_EN - when defined, adds the OVF output, registered at
//                         completion as carry-into-MSB XOR carry-out-of-MSB.
// -----------------------------------------------------------------------------
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             START,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Cin,
    output logic             BUSY,
    output logic             DONE,
    output logic [WIDTH-1:0] SUM,
    output logic             Cout
`ifdef SERIAL_ADDER_OVF_EN
    ,
    output logic             OVF
`endif
);

    localparam int CNT_W = $clog2(WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

    localparam logic [0:0] IDLE  = 1'b0;
    localparam logic [0:0] SHIFT = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic             carry_q, carry_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             done_q, done_d;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q, ovf_d;
`endif

    // The one full-adder cell, fed by the current operand LSBs and carry FF.
    logic bit_sum;
    logic bit_carry;
    logic last_bit;

    always_comb begin
        bit_sum   = a_q[0] ^ b_q[0] ^ carry_q;
        bit_carry = (a_q[0] & b_q[0]) | (a_q[0] & carry_q) | (b_q[0] & carry_q);
        last_bit  = (cnt_q == LAST_BIT);
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        carry_d = carry_q;
        res_d   = res_q;
        cnt_d   = cnt_q;
        sum_d   = sum_q;
        cout_d  = cout_q;
        done_d  = 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
        ovf_d   = ovf_q;
`endif

        case (state_q)
            IDLE: begin
                if (START) begin
                    a_d     = A;
                    b_d     = B;
                    carry_d = Cin;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = SHIFT;
                end
            end

            SHIFT: begin
                a_d     = a_q >> 1;
                b_d     = b_q >> 1;
                // New sum bits enter at the MSB; after WIDTH shifts bit 0
                // has walked down to the LSB position.
                res_d   = {bit_sum, res_q[WIDTH-1:1]};
                carry_d = bit_carry;
                cnt_d   = cnt_q + CNT_W'(1);
                if (last_bit) begin
                    sum_d   = {bit_sum, res_q[WIDTH-1:1]};
                    cout_d  = bit_carry;
`ifdef SERIAL_ADDER_OVF_EN
                    // carry_q is the carry into the MSB on this last step.
                    ovf_d   = carry_q ^ bit_carry;
`endif
                    done_d  = 1'b1;
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            carry_q <= 1'b0;
            res_q   <= '0;
            cnt_q   <= '0;
            sum_q   <= '0;
            cout_q  <= 1'b0;
            done_q  <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            carry_q <= carry_d;
            res_q   <= res_d;
            cnt_q   <= cnt_d;
            sum_q   <= sum_d;
            cout_q  <= cout_d;
            done_q  <= done_d;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q   <= ovf_d;
`endif
        end
    end

    assign BUSY = (state_q == SHIFT);
    assign DONE = done_q;
    assign SUM  = sum_q;
    assign Cout = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign OVF  = ovf_q;
`endif

endmodule

// File: tb/tb_serial_adder.sv
// -----------------------------------------------------------------------------
// tb_serial_adder
//
// Self-checking bench for serial_adder (WIDTH = 8). A table of hand-computed
// vectors is applied in a loop; hand-written sequences cover reset, result
// hold, busy lockout, back-to-back START, and mid-operation abort.
// -----------------------------------------------------------------------------
module tb_serial_adder;

    localparam int WIDTH = 8;

    logic             CLK;
    logic             RST_N;
    logic             START;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             BUSY;
    logic             DONE;
    logic [WIDTH-1:0] SUM;
    logic             Cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             OVF;
`endif

    serial_adder #(.WIDTH(WIDTH)) dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .START (START),
        .A     (A),
        .B     (B),
        .Cin   (Cin),
        .BUSY  (BUSY),
        .DONE  (DONE),
        .SUM   (SUM),
        .Cout  (Cout)
`ifdef SERIAL_ADDER_OVF_EN
        ,
        .OVF   (OVF)
`endif
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] exp_sum;
        logic       exp_cout;
        logic       exp_ovf;
    } vec_t;

    vec_t vecs [10];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Present operands with START at a falling edge; returns after the accept edge.
    task automatic start_op(input logic [7:0] a, input logic [7:0] b, input logic c);
        @(negedge CLK);
        A     = a;
        B     = b;
        Cin   = c;
        START = 1'b1;
        @(posedge CLK);
        #1;
        START = 1'b0;
        // Operands are already captured; scramble the inputs.
        A     = 8'($urandom);
        B     = 8'($urandom);
        Cin   = 1'($urandom);
    endtask

    // Counts edges after the accept edge until DONE is seen (bounded).
    task automatic wait_done(output int lat);
        lat = 0;
        for (int n = 1; n <= 40; n++) begin
            @(posedge CLK);
            #1;
            if (DONE) begin
                lat = n;
                break;
            end
        end
        if (lat == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL done_timeout: got no DONE, expected DONE within 40 cycles");
        end
    endtask

    int lat;
    int extra_done;

    initial begin
        vecs[0] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1, 1'b0};
        vecs[1] = '{8'h5A, 8'h3C, 1'b1, 8'h97, 1'b0, 1'b1};
        vecs[2] = '{8'h00, 8'h00, 1'b0, 8'h00, 1'b0, 1'b0};
        vecs[3] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1, 1'b0};
        vecs[4] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1, 1'b1};
        vecs[5] = '{8'h12, 8'h34, 1'b0, 8'h46, 1'b0, 1'b0};
        vecs[6] = '{8'hAA, 8'h55, 1'b1, 8'h00, 1'b1, 1'b0};
        vecs[7] = '{8'h7F, 8'h01, 1'b0, 8'h80, 1'b0, 1'b1};
        vecs[8] = '{8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0, 1'b0};
        vecs[9] = '{8'hC3, 8'h3C, 1'b1, 8'h00, 1'b1, 1'b0};

        // ---- Reset with random inputs and START high ----
        RST_N = 1'b0;
        START = 1'b1;
        A     = 8'($urandom);
        B     = 8'($urandom);
        Cin   = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            A = 8'($urandom);
            B = 8'($urandom);
            check("rst_busy", 32'(BUSY), 32'd0);
            check("rst_done", 32'(DONE), 32'd0);
            check("rst_sum",  32'(SUM),  32'd0);
            check("rst_cout", 32'(Cout), 32'd0);
        end
`ifdef SERIAL_ADDER_OVF_EN
        check("rst_ovf", 32'(OVF), 32'd0);
`endif
        START = 1'b0;
        RST_N = 1'b1;

        // ---- Table-driven vectors ----
        for (int i = 0; i < 10; i++) begin
            start_op(vecs[i].a, vecs[i].b, vecs[i].cin);
            check($sformatf("v%0d_busy", i), 32'(BUSY), 32'd1);
            wait_done(lat);
            check($sformatf("v%0d_latency", i), 32'(lat), 32'(WIDTH));
            check($sformatf("v%0d_sum", i), 32'(SUM), 32'(vecs[i].exp_sum));
            check($sformatf("v%0d_cout", i), 32'(Cout), 32'(vecs[i].exp_cout));
            check($sformatf("v%0d_busy_at_done", i), 32'(BUSY), 32'd0);
`ifdef SERIAL_ADDER_OVF_EN
            check($sformatf("v%0d_ovf", i), 32'(OVF), 32'(vecs[i].exp_ovf));
`endif
            @(posedge CLK);
            #1;
            check($sformatf("v%0d_done_pulse", i), 32'(DONE), 32'd0);
            $display("[TB] vec %0d: %02h+%02h+%0d -> SUM=%02h Cout=%0d lat=%0d",
                     i, vecs[i].a, vecs[i].b, vecs[i].cin, SUM, Cout, lat);
        end

        // ---- Carry chain result holds while idle ----
        start_op(8'hFF, 8'h01, 1'b0);
        wait_done(lat);
        check("chain_latency", 32'(lat), 32'd8);
        repeat (5) @(posedge CLK);
        #1;
        check("chain_hold_sum",  32'(SUM),  32'h00);
        check("chain_hold_cout", 32'(Cout), 32'd1);
        $display("[TB] chain hold: SUM=%02h Cout=%0d", SUM, Cout);

        // ---- Busy lockout: START during SHIFT is ignored ----
        start_op(8'h10, 8'h20, 1'b0);
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        A     = 8'hFF;
        B     = 8'hFF;
        START = 1'b1;
        @(negedge CLK);
        START = 1'b0;
        // Accept edge + 2 + 1 edges already consumed, so DONE is 5 edges away.
        wait_done(lat);
        check("lock_latency", 32'(lat), 32'd5);
        check("lock_sum",  32'(SUM),  32'h30);
        check("lock_cout", 32'(Cout), 32'd0);
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            if (DONE) extra_done++;
        end
        check("lock_single_done", 32'(extra_done), 32'd0);
        check("lock_idle_busy", 32'(BUSY), 32'd0);
        $display("[TB] lockout: SUM=%02h Cout=%0d extra_done=%0d", SUM, Cout, extra_done);

        // ---- START held high: back-to-back operations ----
        @(negedge CLK);
        A     = 8'h01;
        B     = 8'h02;
        Cin   = 1'b0;
        START = 1'b1;
        @(posedge CLK);
        #1;
        A = 8'h33;
        B = 8'h44;
        wait_done(lat);
        check("b2b_first_latency", 32'(lat), 32'd8);
        check("b2b_first_sum", 32'(SUM), 32'h03);
        check("b2b_gap_busy", 32'(BUSY), 32'd0);
        @(posedge CLK);
        #1;
        check("b2b_reaccept_busy", 32'(BUSY), 32'd1);
        check("b2b_reaccept_done", 32'(DONE), 32'd0);
        START = 1'b0;
        wait_done(lat);
        check("b2b_second_latency", 32'(lat), 32'd8);
        check("b2b_second_sum",  32'(SUM),  32'h77);
        check("b2b_second_cout", 32'(Cout), 32'd0);
        $display("[TB] back-to-back: second SUM=%02h lat=%0d", SUM, lat);

        // ---- Abort by reset mid-operation ----
        start_op(8'hF0, 8'h0F, 1'b0);
        repeat (3) @(posedge CLK);
        #2;
        RST_N = 1'b0;
        #1;
        check("abort_busy", 32'(BUSY), 32'd0);
        check("abort_sum",  32'(SUM),  32'd0);
        check("abort_cout", 32'(Cout), 32'd0);
        @(negedge CLK);
        @(negedge CLK);
        RST_N = 1'b1;
        extra_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            if (DONE || BUSY) extra_done++;
        end
        check("abort_no_done", 32'(extra_done), 32'd0);
        start_op(8'hF0, 8'h0F, 1'b0);
        wait_done(lat);
        check("rerun_latency", 32'(lat), 32'd8);
        check("rerun_sum",  32'(SUM),  32'hFF);
        check("rerun_cout", 32'(Cout), 32'd0);
        $display("[TB] abort+rerun: SUM=%02h Cout=%0d", SUM, Cout);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/serial_adder.md
# serial_adder

Bit-serial WIDTH-bit adder built around a single full-adder cell and a carry flip-flop. It sits directly upstream of the full-adder stage: it captures two parallel operands, feeds them LSB-first one bit per clock through full-adder logic (A, B, Cin → SUM, Cout), and reassembles the parallel result. It trades WIDTH cycles of latency for one adder cell plus shift registers.

## Interface
Parameters:
- WIDTH, 8, operand and result width in bits (≥ 2)

Ports:
- CLK  input  1  system clock; all state updates on rising edge
- RST_N  input  1  asynchronous, active-low reset
- START  input  1  load request; sampled only when BUSY = 0
- A  input  WIDTH  operand A, captured on the accepted START edge
- B  input  WIDTH  operand B, captured on the accepted START edge
- Cin  input  1  carry-in, captured on the accepted START edge
- BUSY  output  1  high while an addition is in progress
- DONE  output  1  single-cycle pulse: SUM/Cout just updated
- SUM  output  WIDTH  registered result; holds until the next completion
- Cout  output  1  registered carry-out of bit WIDTH-1

## Operation
- Internal state: A shift register, B shift register, carry FF, result shift register, bit counter (clog2(WIDTH) bits), FSM.
- FSM states:
  - IDLE: BUSY = 0. On START = 1, load A, B and Cin into the carry FF. Clear the counter and go to SHIFT.
  - SHIFT: BUSY = 1. Each edge computes s = a0 ^ b0 ^ c and c' = a0&b0 | a0&c | b0&c on the current LSBs (a0, b0) and carry c. It shifts A/B right by one, shifts s into the MSB of the result register, stores c' in the carry FF and increments the counter.
  - When the counter reaches WIDTH-1 (last bit processed on that edge): transfer the completed result to SUM and the final c' to Cout, assert DONE for the next cycle, and return to IDLE.
- START while BUSY = 1 is ignored. No queuing and no operand recapture.
- START held high continuously: a new operation is accepted on the first IDLE edge after completion, giving back-to-back throughput of one result per WIDTH+1 cycles.
- Arithmetic is unsigned modulo 2^WIDTH, so {Cout, SUM} = A + B + Cin exactly.
- A and B inputs may change freely while BUSY = 1.

## Timing
- Reset values (asynchronous, immediate on RST_N low):
  - FSM = IDLE
  - BUSY = 0, DONE = 0
  - SUM = 0, Cout = 0
  - counter, shift registers and carry FF = 0
- Reset mid-operation aborts the addition. SUM/Cout read 0 and no DONE is produced.
- Edge 0 accepts START, and BUSY rises after edge 0.
- Edges 1..WIDTH process bits 0..WIDTH-1.
- SUM, Cout and DONE update at edge WIDTH, and BUSY falls at the same edge.
- Latency from the START-accept edge to valid SUM with DONE = 1 is WIDTH cycles.
- DONE is high for exactly one cycle. A new START may be accepted at edge WIDTH+1, while DONE is still high.

## Configuration
- SERIAL_ADDER_OVF_EN defined:
  - Adds output port OVF (1 bit, reset 0), registered alongside SUM.
  - OVF = carry into bit WIDTH-1 XOR carry out of bit WIDTH-1, i.e. two's-complement signed overflow.
  - OVF updates only at completion.
- SERIAL_ADDER_OVF_EN undefined: the OVF port and its logic are absent. All other behaviour is identical.

## Test plan
- Reset: hold RST_N = 0 with random inputs and START = 1. Required: BUSY = DONE = SUM = Cout = 0. After release, the first START is accepted normally.
- Carry chain: A = 8'hFF, B = 8'h01, Cin = 0, START one cycle. Required: DONE exactly 8 cycles after the accept edge, SUM = 8'h00, Cout = 1. SUM holds 8'h00 until the next completion.
- Carry-in: A = 8'h5A, B = 8'h3C, Cin = 1. Required: SUM = 8'h97, Cout = 0.
- Busy lockout: start A = 8'h10, B = 8'h20, Cin = 0. At cycle 3, pulse START with A = 8'hFF, B = 8'hFF. Required: single DONE, SUM = 8'h30, Cout = 0, BUSY low for exactly one cycle before any later accept.
- Abort: start 8'hF0 + 8'h0F. Assert RST_N = 0 at cycle 4. Required: BUSY and SUM go to 0 immediately and no DONE follows. Then rerun and get SUM = 8'hFF, Cout = 0.
- OVF (macro defined): 8'h7F + 8'h01 gives SUM = 8'h80, OVF = 1, Cout = 0. 8'hFF + 8'h01 gives OVF = 0, Cout = 1.
